instr_mem_receiver: RTL and testbench
=====================================

// Module: instr_mem_receiver
// PURPOSE
//  Receiving end of the instruction-load stream: one {load_address, load_data} beat per clock while load_en=1.
//  Writes each word into an internal DEPTH x 32 instruction RAM and tracks a complete in-order pass 0..DEPTH-1.
//  After a complete pass, serves registered CPU instruction fetches and raises ready, which releases the core.
//  Sits between the instruction loader and the CPU fetch stage.
// PARAMETERS
//  DEPTH   64  instruction words held; load_address is a word index, 0..DEPTH-1
//  ADDR_W  6   log2(DEPTH); index width
// PORTS
//  clock         in   1       system clock; all state on posedge
//  reset         in   1       asynchronous, active-high reset
//  load_en       in   1       1 = load_address/load_data carry a valid beat this cycle
//  load_address  in   32      word index of the beat
//  load_data     in   32      instruction word of the beat
//  reload        in   1       1-cycle pulse: discard READY and start a new load pass
//  fetch_pc      in   32      CPU byte address; word index = fetch_pc[ADDR_W+1:2]
//  fetch_instr   out  32      registered instruction for fetch_pc
//  fetch_valid   out  1       fetch_instr is valid (READY state only)
//  ready         out  1       complete pass stored; CPU may run
//  load_count    out  ADDR_W+1 length of the current in-order run, 0..DEPTH
//  addr_error    out  1       1-cycle pulse on a bad load or fetch address
// BEHAVIOUR
//  Reset (async, any time, including mid-load): state=LOAD; load_count, ready, fetch_valid, fetch_instr and addr_error = 0.
//  RAM contents are not cleared by reset or reload.
//  FSM has two states: LOAD and READY.
//  LOAD, each cycle with load_en=1:
//   - load_address < DEPTH: mem[load_address[ADDR_W-1:0]] <= load_data.
//   - load_address == load_count: load_count <= load_count+1.
//   - load_address != load_count (in range): out-of-sequence. addr_error pulses; load_count <= (load_address==0) ? 1 : 0.
//   - load_address >= DEPTH: no write; addr_error pulses; load_count <= 0.
//   - In-sequence beat with load_address == DEPTH-1: next state READY.
//     ready=1 and load_count=DEPTH on the following cycle.
//  LOAD, load_en=0: no change. fetch_valid=0 and fetch_instr holds 0.
//  READY:
//   - load beats are ignored (no write, no addr_error); ready stays 1.
//   - Fetch latency is 1 cycle: fetch_instr <= mem[fetch_pc[ADDR_W+1:2]], fetch_valid <= 1.
//   - fetch_pc[1:0] are ignored.
//   - If fetch_pc[31:ADDR_W+2] != 0: fetch_instr <= 0, fetch_valid <= 1, addr_error pulses.
//  reload=1 in any state takes priority over a same-cycle load beat; that beat is dropped (no write).
//   Next cycle: state=LOAD, load_count=0, ready=0, fetch_valid=0, fetch_instr=0.
//  A wrapped stream (...DEPTH-1, 0, 1...) arriving in LOAD restarts the run at 0 with load_count=1 and no error.
//  addr_error is registered and high for exactly one cycle per offending beat or fetch.
// TESTING
//  1. Reset, then stream 0..63 with data 0x1000+i, load_en=1 -> ready=1 one cycle after address 63 beat;
//     fetch_pc=0x4 -> fetch_instr=0x1001 next cycle; fetch_pc=0xFC -> 0x103F.
//  2. Stream 0..9, then 20 -> addr_error pulse and load_count=0; then 0..63 in order -> ready=1, no further errors.
//  3. Beat address 64 with data 0xDEADBEEF mid-load -> no write, addr_error pulse, load_count=0;
//     after a full pass, fetch_pc=0x0 returns the pass data, not 0xDEADBEEF.
//  4. Assert reset at address 30 of a pass -> load_count=0, ready=0 immediately;
//     a new 0..63 pass -> ready=1 after address 63.
//  5. In READY, pulse reload together with a beat to address 0 -> beat dropped, ready=0, load_count=0 next cycle;
//     a second full pass with new data -> fetches return the new data.
//  6. In READY, fetch_pc=0x100 -> fetch_instr=0, fetch_valid=1, addr_error pulse;
//     load beats in READY -> RAM unchanged.

Source files
------------

// File: rtl/instr_mem_receiver.sv
// Instruction RAM fed by the loader stream; releases the CPU (ready) after a full in-order pass 0..DEPTH-1.
// Fetch latency 1 cycle; no backpressure, a load beat is taken or rejected every cycle load_en is high.
module instr_mem_receiver #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_en,
  input  logic [31:0]       load_address,
  input  logic [31:0]       load_data,
  input  logic              reload,
  input  logic [31:0]       fetch_pc,
  output logic [31:0]       fetch_instr,
  output logic              fetch_valid,
  output logic              ready,
  output logic [ADDR_W:0]   load_count,
  output logic              addr_error
);

  typedef enum logic {S_LOAD, S_READY} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   load_count_q, load_count_d;
  logic [31:0]       fetch_instr_q, fetch_instr_d;
  logic              fetch_valid_q, fetch_valid_d;
  logic              addr_error_q, addr_error_d;
  logic              mem_we;
  logic [31:0]       mem_q [DEPTH];

  logic              addr_in_range;
  logic              addr_in_seq;
  logic              addr_is_last;
  logic              addr_is_zero;
  logic [ADDR_W-1:0] load_idx;
  logic [ADDR_W-1:0] fetch_idx;
  logic              fetch_pc_bad;
  logic              unused_pc_lsbs;

  assign load_idx       = load_address[ADDR_W-1:0];
  assign addr_in_range  = load_address < 32'(DEPTH);
  assign addr_in_seq    = load_address == 32'(load_count_q);
  assign addr_is_last   = load_idx == ADDR_W'(DEPTH - 1);
  assign addr_is_zero   = load_idx == '0;
  assign fetch_idx      = fetch_pc[ADDR_W+1:2];
  assign fetch_pc_bad   = |fetch_pc[31:ADDR_W+2];
  assign unused_pc_lsbs = ^fetch_pc[1:0];

  always_comb begin
    state_d       = state_q;
    load_count_d  = load_count_q;
    fetch_instr_d = fetch_instr_q;
    fetch_valid_d = fetch_valid_q;
    addr_error_d  = 1'b0;
    mem_we        = 1'b0;
    if (reload) begin
      // Reload wins over a same-cycle beat; that beat is dropped without a write.
      state_d       = S_LOAD;
      load_count_d  = '0;
      fetch_instr_d = '0;
      fetch_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_LOAD: begin
          fetch_instr_d = '0;
          fetch_valid_d = 1'b0;
          if (load_en) begin
            if (addr_in_range) begin
              mem_we = 1'b1;
              if (addr_in_seq) begin
                load_count_d = load_count_q + {{ADDR_W{1'b0}}, 1'b1};
                if (addr_is_last) state_d = S_READY;
              end else begin
                // A beat to word 0 starts a fresh run rather than leaving it empty.
                addr_error_d = 1'b1;
                load_count_d = addr_is_zero ? {{ADDR_W{1'b0}}, 1'b1} : '0;
              end
            end else begin
              addr_error_d = 1'b1;
              load_count_d = '0;
            end
          end
        end
        S_READY: begin
          fetch_valid_d = 1'b1;
          if (fetch_pc_bad) begin
            fetch_instr_d = '0;
            addr_error_d  = 1'b1;
          end else begin
            fetch_instr_d = mem_q[fetch_idx];
          end
        end
        default: state_d = S_LOAD;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_LOAD;
      load_count_q  <= '0;
      fetch_instr_q <= '0;
      fetch_valid_q <= 1'b0;
      addr_error_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      load_count_q  <= load_count_d;
      fetch_instr_q <= fetch_instr_d;
      fetch_valid_q <= fetch_valid_d;
      addr_error_q  <= addr_error_d;
    end
  end

  // RAM is deliberately outside the reset domain; contents survive reset and reload.
  always_ff @(posedge clock) begin
    if (mem_we) mem_q[load_idx] <= load_data;
  end

  assign fetch_instr = fetch_instr_q;
  assign fetch_valid = fetch_valid_q;
  assign ready       = (state_q == S_READY);
  assign load_count  = load_count_q;
  assign addr_error  = addr_error_q;

endmodule

// File: tb/tb_instr_mem_receiver.sv
// Directed bench for instr_mem_receiver: table of READY-state vectors plus hand sequences for load/reload/reset.
module tb_instr_mem_receiver;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        load_en = 1'b0;
  logic [31:0] load_address = '0;
  logic [31:0] load_data = '0;
  logic        reload = 1'b0;
  logic [31:0] fetch_pc = '0;
  logic [31:0] fetch_instr;
  logic        fetch_valid;
  logic        ready;
  logic [6:0]  load_count;
  logic        addr_error;

  int n_checks = 0;
  int n_pass   = 0;

  instr_mem_receiver #(.DEPTH(64), .ADDR_W(6)) dut (
    .clock        (clock),
    .reset        (reset),
    .load_en      (load_en),
    .load_address (load_address),
    .load_data    (load_data),
    .reload       (reload),
    .fetch_pc     (fetch_pc),
    .fetch_instr  (fetch_instr),
    .fetch_valid  (fetch_valid),
    .ready        (ready),
    .load_count   (load_count),
    .addr_error   (addr_error)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        le;
    logic [31:0] addr;
    logic [31:0] data;
    logic        rl;
    logic [31:0] pc;
    logic        e_ready;
    logic [6:0]  e_cnt;
    logic        e_err;
    logic        e_vld;
    logic [31:0] e_instr;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic apply(input logic le, input logic [31:0] addr, input logic [31:0] data,
                       input logic rl, input logic [31:0] pc);
    load_en      = le;
    load_address = addr;
    load_data    = data;
    reload       = rl;
    fetch_pc     = pc;
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    apply(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic check_state(input string tag, input logic e_ready, input logic [6:0] e_cnt,
                             input logic e_err, input logic e_vld, input logic [31:0] e_instr);
    check({tag, "_ready"}, 32'(ready), 32'(e_ready));
    check({tag, "_count"}, 32'(load_count), 32'(e_cnt));
    check({tag, "_err"},   32'(addr_error), 32'(e_err));
    check({tag, "_vld"},   32'(fetch_valid), 32'(e_vld));
    check({tag, "_instr"}, fetch_instr, e_instr);
  endtask

  // Streams addresses lo..hi with data base+addr; counts error pulses seen along the way.
  task automatic stream(input int lo, input int hi, input logic [31:0] base, output int errs);
    errs = 0;
    for (int a = lo; a <= hi; a++) begin
      apply(1'b1, 32'(a), base + 32'(a), 1'b0, 32'h0);
      if (addr_error !== 1'b0) errs++;
    end
  endtask

  task automatic full_pass(input string tag, input logic [31:0] base);
    int errs;
    stream(0, 62, base, errs);
    check({tag, "_cnt63"},   32'(load_count), 32'd63);
    check({tag, "_notrdy"},  32'(ready), 32'd0);
    stream(63, 63, base, errs);
    check({tag, "_errs"},    32'(errs), 32'd0);
    check({tag, "_ready"},   32'(ready), 32'd1);
    check({tag, "_cnt64"},   32'(load_count), 32'd64);
  endtask

  task automatic fetch(input string tag, input logic [31:0] pc, input logic [31:0] exp);
    apply(1'b0, 32'h0, 32'h0, 1'b0, pc);
    check({tag, "_instr"}, fetch_instr, exp);
    check({tag, "_vld"},   32'(fetch_valid), 32'd1);
  endtask

  initial begin
    int errs;

    //          le    addr          data          rl    pc             rdy   cnt  err   vld   instr
    tbl[0] = '{1'b0, 32'h0,        32'h0,        1'b0, 32'h0000_0004, 1'b1, 7'd64, 1'b0, 1'b1, 32'h1001};
    tbl[1] = '{1'b0, 32'h0,        32'h0,        1'b0, 32'h0000_00FC, 1'b1, 7'd64, 1'b0, 1'b1, 32'h103F};
    tbl[2] = '{1'b0, 32'h0,        32'h0,        1'b0, 32'h0000_00FF, 1'b1, 7'd64, 1'b0, 1'b1, 32'h103F};
    tbl[3] = '{1'b0, 32'h0,        32'h0,        1'b0, 32'h0000_0100, 1'b1, 7'd64, 1'b1, 1'b1, 32'h0};
    tbl[4] = '{1'b0, 32'h0,        32'h0,        1'b0, 32'h0000_0000, 1'b1, 7'd64, 1'b0, 1'b1, 32'h1000};
    tbl[5] = '{1'b1, 32'd5,        32'hBAD,      1'b0, 32'h0000_0014, 1'b1, 7'd64, 1'b0, 1'b1, 32'h1005};
    tbl[6] = '{1'b0, 32'h0,        32'h0,        1'b0, 32'h0000_0014, 1'b1, 7'd64, 1'b0, 1'b1, 32'h1005};
    tbl[7] = '{1'b1, 32'd99,       32'hBAD,      1'b0, 32'h0000_0008, 1'b1, 7'd64, 1'b0, 1'b1, 32'h1002};
    tbl[8] = '{1'b0, 32'h0,        32'h0,        1'b0, 32'h8000_0000, 1'b1, 7'd64, 1'b1, 1'b1, 32'h0};
    tbl[9] = '{1'b0, 32'h0,        32'h0,        1'b0, 32'h0000_0010, 1'b1, 7'd64, 1'b0, 1'b1, 32'h1004};

    // Reset state
    @(posedge clock); #1;
    @(posedge clock); #1;
    check_state("rst", 1'b0, 7'd0, 1'b0, 1'b0, 32'h0);
    reset = 1'b0;
    idle();
    check_state("idle", 1'b0, 7'd0, 1'b0, 1'b0, 32'h0);

    // Full pass, then READY-state vector table
    full_pass("p1", 32'h1000);
    for (int i = 0; i < 10; i++) begin
      apply(tbl[i].le, tbl[i].addr, tbl[i].data, tbl[i].rl, tbl[i].pc);
      check_state($sformatf("vec%0d", i), tbl[i].e_ready, tbl[i].e_cnt,
                  tbl[i].e_err, tbl[i].e_vld, tbl[i].e_instr);
    end

    // Reload together with a beat to address 0: beat dropped, outputs cleared
    apply(1'b1, 32'h0, 32'hAAAA_AAAA, 1'b1, 32'h0);
    check_state("reload", 1'b0, 7'd0, 1'b0, 1'b0, 32'h0);
    full_pass("p2", 32'h2000);
    fetch("p2_f0", 32'h0, 32'h2000);
    fetch("p2_f10", 32'h10, 32'h2004);

    // Out-of-sequence beat mid-load
    apply(1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
    stream(0, 9, 32'h3000, errs);
    check("oos_pre_errs", 32'(errs), 32'd0);
    check("oos_pre_cnt", 32'(load_count), 32'd10);
    apply(1'b1, 32'd20, 32'h3014, 1'b0, 32'h0);
    check("oos_err", 32'(addr_error), 32'd1);
    check("oos_cnt", 32'(load_count), 32'd0);
    idle();
    check("oos_err_1cyc", 32'(addr_error), 32'd0);
    full_pass("p3", 32'h3000);

    // Out-of-range beat mid-load (index bits alias word 0)
    apply(1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
    stream(0, 4, 32'h4000, errs);
    apply(1'b1, 32'd64, 32'hDEAD_BEEF, 1'b0, 32'h0);
    check("oor_err", 32'(addr_error), 32'd1);
    check("oor_cnt", 32'(load_count), 32'd0);
    full_pass("p4", 32'h4000);
    fetch("p4_f0", 32'h0, 32'h4000);

    // Restart at 0 after a failed run counts as 1 with no error
    apply(1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
    stream(0, 2, 32'h6000, errs);
    apply(1'b1, 32'd63, 32'h603F, 1'b0, 32'h0);
    check("wrap_err63", 32'(addr_error), 32'd1);
    check("wrap_notrdy", 32'(ready), 32'd0);
    apply(1'b1, 32'd0, 32'h6000, 1'b0, 32'h0);
    check("wrap_err0", 32'(addr_error), 32'd0);
    check("wrap_cnt", 32'(load_count), 32'd1);

    // Asynchronous reset at address 30 of a pass
    apply(1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
    stream(0, 30, 32'h5000, errs);
    check("ar_pre_cnt", 32'(load_count), 32'd31);
    #2 reset = 1'b1;
    #1;
    check("ar_cnt", 32'(load_count), 32'd0);
    check("ar_ready", 32'(ready), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    full_pass("p5", 32'h5000);
    fetch("p5_f7c", 32'h7C, 32'h501F);

    // Asynchronous reset while READY drops ready immediately
    #2 reset = 1'b1;
    #1;
    check("ar_rdy_ready", 32'(ready), 32'd0);
    check("ar_rdy_vld", 32'(fetch_valid), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
